spook_out_pkt_buffer: RTL and testbench

//  Store-and-forward packet buffer on the spook_MSK status/output bus. It accepts

---
 rtl/spook_out_pkt_buffer.sv | 160 ++++++++++++++++
 tb/tb_spook_out_pkt_buffer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spook_out_pkt_buffer.sv
// Store-and-forward buffer for the spook_MSK output bus: a packet becomes
// visible to the host only after its last word has been written.
module spook_out_pkt_buffer #(
    parameter int BUS_SIZE = 32,
    parameter int DEPTH    = 64,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic [BUS_SIZE-1:0] in_data,
    input  logic                in_valid,
    input  logic                in_last,
    output logic                in_ready,
    output logic [BUS_SIZE-1:0] out_data,
    output logic                out_valid,
    output logic                out_last,
    input  logic                out_ready,
    output logic [CNT_W-1:0]    pkt_count,
    output logic                overflow_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

    typedef enum logic {
        RECV,
        DROP
    } state_t;

    state_t                state_q, state_d;
    logic [AW:0]           wr_ptr_q, wr_ptr_d;
    logic [AW:0]           cm_ptr_q, cm_ptr_d;
    logic [AW:0]           rd_ptr_q, rd_ptr_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;
    logic [BUS_SIZE-1:0]   out_data_q, out_data_d;
    logic [CNT_W-1:0]      pkt_count_q, pkt_count_d;
    logic                  overflow_q, overflow_d;

    logic [BUS_SIZE:0]     mem [DEPTH];
    logic [BUS_SIZE:0]     rd_word;
    logic [AW:0]           used;
    logic [AW:0]           pending;
    logic                  full;
    logic                  overrun;
    logic                  in_xfer;
    logic                  wr_en;
    logic                  commit;
    logic                  load;
    logic                  pop_last;

    assign used     = wr_ptr_q - rd_ptr_q;
    assign pending  = wr_ptr_q - cm_ptr_q;
    assign full     = (used == FULL_CNT);
    assign in_ready = (state_q == DROP) | ~full;
    assign in_xfer  = in_valid & in_ready;
    assign wr_en    = (state_q == RECV) & in_xfer & ~flush;
    assign commit   = wr_en & in_last;
    // A single unfinished packet occupying every slot can never commit.
    assign overrun  = (state_q == RECV) & full & (pending == FULL_CNT);
    assign load     = (rd_ptr_q != cm_ptr_q) & (~out_valid_q | out_ready);
    assign pop_last = out_valid_q & out_ready & out_last_q;
    assign rd_word  = mem[rd_ptr_q[AW-1:0]];

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        cm_ptr_d    = cm_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        pkt_count_d = pkt_count_q;
        overflow_d  = overflow_q;

        if (state_q == RECV) begin
            if (overrun) begin
                wr_ptr_d   = cm_ptr_q;
                overflow_d = 1'b1;
                state_d    = DROP;
            end else if (in_xfer) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (in_last) begin
                    cm_ptr_d = wr_ptr_q + 1'b1;
                end
            end
        end else if (in_xfer & in_last) begin
            state_d = RECV;
        end

        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = rd_word[BUS_SIZE-1:0];
            out_last_d  = rd_word[BUS_SIZE];
            rd_ptr_d    = rd_ptr_q + 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        if (commit & ~pop_last) begin
            if (~&pkt_count_q) begin
                pkt_count_d = pkt_count_q + 1'b1;
            end
        end else if (pop_last & ~commit) begin
            if (pkt_count_q != '0) begin
                pkt_count_d = pkt_count_q - 1'b1;
            end
        end

        if (flush) begin
            state_d     = RECV;
            wr_ptr_d    = '0;
            cm_ptr_d    = '0;
            rd_ptr_d    = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_data_d  = '0;
            pkt_count_d = '0;
            overflow_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RECV;
            wr_ptr_q    <= '0;
            cm_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            pkt_count_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            cm_ptr_q    <= cm_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            pkt_count_q <= pkt_count_d;
            overflow_q  <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q[AW-1:0]] <= {in_last, in_data};
        end
    end

    assign out_data     = out_data_q;
    assign out_valid    = out_valid_q;
    assign out_last     = out_last_q;
    assign pkt_count    = pkt_count_q;
    assign overflow_err = overflow_q;

endmodule

// File: tb/tb_spook_out_pkt_buffer.sv
// Bench for spook_out_pkt_buffer: packet-level scoreboard checked every
// cycle, plus directed scenarios with literal expectations.
module tb_spook_out_pkt_buffer;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_last;
    logic        out_ready;
    logic [7:0]  pkt_count;
    logic        overflow_err;

    spook_out_pkt_buffer dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_last     (out_last),
        .out_ready    (out_ready),
        .pkt_count    (pkt_count),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: committed words awaiting delivery, and the packet being received.
    logic [32:0] exp_q[$];
    logic [32:0] cur_q[$];
    int          cur_len   = 0;
    bit          dropping  = 0;
    bit          ovf_exp   = 0;
    bit          ovf_delay = 0;
    int          pkt_exp   = 0;
    int          n_out     = 0;
    int          n_pkt_out = 0;
    bit          rand_rdy  = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        cur_q.delete();
        cur_len   = 0;
        dropping  = 0;
        ovf_exp   = 0;
        ovf_delay = 0;
        pkt_exp   = 0;
    endtask

    always @(negedge clk) begin
        if (!rst) model_clear();
        if (exp_q.size() == 0) begin
            chk("out_valid_uncommitted", {63'd0, out_valid}, 64'd0);
        end else if (out_valid) begin
            chk("out_data", {32'd0, out_data}, {32'd0, exp_q[0][31:0]});
            chk("out_last", {63'd0, out_last}, {63'd0, exp_q[0][32]});
        end
        chk("pkt_count", {56'd0, pkt_count}, 64'(pkt_exp));
        chk("overflow_err", {63'd0, overflow_err}, {63'd0, ovf_exp});
        if (rst) begin
            if (flush) begin
                model_clear();
            end else begin
                if (ovf_delay) begin
                    ovf_exp   = 1;
                    ovf_delay = 0;
                end
                if (out_valid && out_ready && exp_q.size() != 0) begin
                    if (exp_q[0][32]) begin
                        pkt_exp--;
                        n_pkt_out++;
                    end
                    void'(exp_q.pop_front());
                    n_out++;
                end
                if (in_valid && in_ready) begin
                    cur_len++;
                    if (!dropping) begin
                        cur_q.push_back({in_last, in_data});
                        if (!in_last && cur_len == DEPTH) begin
                            dropping  = 1;
                            ovf_delay = 1;
                            cur_q.delete();
                        end
                    end
                    if (in_last) begin
                        if (!dropping) begin
                            foreach (cur_q[i]) exp_q.push_back(cur_q[i]);
                            pkt_exp++;
                        end
                        cur_q.delete();
                        cur_len  = 0;
                        dropping = 0;
                    end
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        int t = 0;
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("send_timeout", {63'd0, in_ready}, 64'd1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < 5000) begin
            step();
            t++;
        end
        chk("drain_timeout", {63'd0, (exp_q.size() == 0 && !out_valid)}, 64'd1);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n0;
        int p0;
        rst       = 1'b0;
        flush     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        idle(3);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_last", {63'd0, out_last}, 64'd0);
        chk("rst_out_data", {32'd0, out_data}, 64'd0);
        chk("rst_pkt_count", {56'd0, pkt_count}, 64'd0);
        chk("rst_overflow", {63'd0, overflow_err}, 64'd0);
        rst = 1'b1;
        step();
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Three-word packet, nothing visible before the last word.
        out_ready = 1'b1;
        send(32'hA0A0_0001, 1'b0);
        chk("t1_hold_a", {63'd0, out_valid}, 64'd0);
        send(32'hB0B0_0002, 1'b0);
        chk("t1_hold_b", {63'd0, out_valid}, 64'd0);
        send(32'hC0C0_0003, 1'b1);
        chk("t1_hold_c", {63'd0, out_valid}, 64'd0);
        chk("t1_cnt1", {56'd0, pkt_count}, 64'd1);
        step();
        chk("t1_a_valid", {63'd0, out_valid}, 64'd1);
        chk("t1_a_data", {32'd0, out_data}, 64'hA0A0_0001);
        step();
        chk("t1_b_data", {32'd0, out_data}, 64'hB0B0_0002);
        chk("t1_b_last", {63'd0, out_last}, 64'd0);
        step();
        chk("t1_c_data", {32'd0, out_data}, 64'hC0C0_0003);
        chk("t1_c_last", {63'd0, out_last}, 64'd1);
        chk("t1_c_cnt", {56'd0, pkt_count}, 64'd1);
        step();
        chk("t1_done_valid", {63'd0, out_valid}, 64'd0);
        chk("t1_done_cnt", {56'd0, pkt_count}, 64'd0);

        // Fill: the output register holds one word, so 65 words fill it.
        out_ready = 1'b0;
        n0 = n_out;
        for (int i = 0; i < 32; i++) send(32'h2000_0000 + i, i == 31);
        for (int i = 0; i < 33; i++) send(32'h2000_0020 + i, i == 32);
        chk("t2_full_ready", {63'd0, in_ready}, 64'd0);
        chk("t2_full_cnt", {56'd0, pkt_count}, 64'd2);
        out_ready = 1'b1;
        wait_drain();
        chk("t2_ready_back", {63'd0, in_ready}, 64'd1);
        chk("t2_words_out", 64'(n_out - n0), 64'd65);

        // Oversize packet is dropped and flagged.
        n0 = n_out;
        for (int i = 1; i <= 70; i++) send(32'h3000_0000 + i, i == 70);
        chk("t3_overflow", {63'd0, overflow_err}, 64'd1);
        chk("t3_cnt", {56'd0, pkt_count}, 64'd0);
        chk("t3_nothing_out", 64'(n_out - n0), 64'd0);
        send(32'h3D00_0000, 1'b0);
        send(32'h3D00_0001, 1'b1);
        wait_drain();
        chk("t3_next_pkt", 64'(n_out - n0), 64'd2);

        // Commit and final-word pop on the same edge.
        out_ready = 1'b0;
        send(32'h4000_0000, 1'b1);
        idle(2);
        chk("t4_cnt_pre", {56'd0, pkt_count}, 64'd1);
        chk("t4_valid_pre", {63'd0, out_valid}, 64'd1);
        send(32'h4100_0000, 1'b0);
        out_ready = 1'b1;
        send(32'h4100_0001, 1'b1);
        chk("t4_cnt_hold", {56'd0, pkt_count}, 64'd1);
        wait_drain();
        chk("t4_cnt_end", {56'd0, pkt_count}, 64'd0);

        // Random stalls on both sides.
        p0 = n_pkt_out;
        rand_rdy = 1;
        for (int p = 0; p < 1000; p++) begin
            int len;
            len = $urandom_range(1, 40);
            for (int w = 0; w < len; w++) begin
                if ($urandom_range(0, 3) == 0) idle(1);
                send($urandom, w == len - 1);
            end
        end
        rand_rdy = 0;
        step();
        out_ready = 1'b1;
        wait_drain();
        chk("t5_packets", 64'(n_pkt_out - p0), 64'd1000);

        // Flush mid-packet clears everything, including the sticky flag.
        out_ready = 1'b0;
        send(32'h6000_0000, 1'b1);
        idle(2);
        send(32'h6100_0000, 1'b0);
        send(32'h6100_0001, 1'b0);
        chk("t6_ovf_sticky", {63'd0, overflow_err}, 64'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("t6f_valid", {63'd0, out_valid}, 64'd0);
        chk("t6f_data", {32'd0, out_data}, 64'd0);
        chk("t6f_last", {63'd0, out_last}, 64'd0);
        chk("t6f_cnt", {56'd0, pkt_count}, 64'd0);
        chk("t6f_ovf", {63'd0, overflow_err}, 64'd0);
        chk("t6f_ready", {63'd0, in_ready}, 64'd1);
        out_ready = 1'b1;
        n0 = n_out;
        send(32'h6200_0000, 1'b0);
        send(32'h6200_0001, 1'b1);
        wait_drain();
        chk("t6f_next_pkt", 64'(n_out - n0), 64'd2);

        // Reset asserted while a packet drains.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(32'h7000_0000 + i, i == 3);
        idle(2);
        out_ready = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("t6r_valid", {63'd0, out_valid}, 64'd0);
        chk("t6r_data", {32'd0, out_data}, 64'd0);
        chk("t6r_last", {63'd0, out_last}, 64'd0);
        chk("t6r_cnt", {56'd0, pkt_count}, 64'd0);
        chk("t6r_ovf", {63'd0, overflow_err}, 64'd0);
        step();
        rst = 1'b1;
        step();
        chk("t6r_ready", {63'd0, in_ready}, 64'd1);
        n0 = n_out;
        for (int i = 0; i < 3; i++) send(32'h7100_0000 + i, i == 2);
        wait_drain();
        chk("t6r_next_pkt", 64'(n_out - n0), 64'd3);

        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
